// File: rtl/uart_tx_piso_if.sv
// Signal bundle between an external UART TX controller and the uart_tx_piso datapath.
// The controller side (master) drives load/shift/even_odd/p_data_in.
// The datapath side (slave) returns the baud tick, the parity bit, the empty flag and the line.
interface uart_tx_piso_if;
    logic       load;
    logic       shift;
    logic       even_odd;
    logic [7:0] p_data_in;
    logic       baud_tick;
    logic       parity_bit;
    logic       tx_empty;
    logic       serial_out;

    modport master (
        output load,
        output shift,
        output even_odd,
        output p_data_in,
        input  baud_tick,
        input  parity_bit,
        input  tx_empty,
        input  serial_out
    );

    modport slave (
        input  load,
        input  shift,
        input  even_odd,
        input  p_data_in,
        output baud_tick,
        output parity_bit,
        output tx_empty,
        output serial_out
    );
endinterface

// File: rtl/uart_tx_piso.sv
// UART transmit datapath: free-running baud divider, parity generator and
// parallel-in/serial-out frame register, all clocked by sys_clk.
// An external FSM issues load/shift; every register update is qualified by baud_tick,
// so each serial bit is held for exactly DIV sys_clk cycles. Bits leave LSB first.
// Build option: define PISO_PARITY_EN for an 11-bit frame {stop, parity, data, start};
// leave it undefined for a 10-bit frame {stop, data, start}. parity_bit is driven either way.
module uart_tx_piso #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DIV       = CLK_FREQ / BAUD_RATE
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    uart_tx_piso_if.slave bus
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int                 BIT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_FULL = BIT_W'(FRAME_LEN);

    // Baud divider state
    logic [CNT_W-1:0]     baud_cnt_reg;
    logic [CNT_W-1:0]     baud_cnt_next;
    logic                 baud_tick_reg;
    logic                 baud_tick_next;

    // Frame state
    logic [FRAME_LEN-1:0] frame_reg;
    logic [FRAME_LEN-1:0] frame_next;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic                 serial_reg;
    logic                 serial_next;

    // Derived frame values
    logic                 parity_bit;
    logic [FRAME_LEN-1:0] load_frame;
    logic [FRAME_LEN-1:0] shifted_frame;

    // Divider next state; the tick is registered from the next count so it is high
    // exactly while the count sits at DIV-1, without decode glitches on the output.
    always_comb begin
        baud_cnt_next  = baud_cnt_reg;
        baud_tick_next = 1'b0;
        if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_next = '0;
        end else begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
        end
        baud_tick_next = (baud_cnt_next == CNT_LAST);
    end

    // Divider registers; free-running from reset release
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg  <= '0;
            baud_tick_reg <= 1'b0;
        end else begin
            baud_cnt_reg  <= baud_cnt_next;
            baud_tick_reg <= baud_tick_next;
        end
    end

    // Parity follows p_data_in directly; 1 selects even parity, 0 selects odd
    assign parity_bit = bus.even_odd ? (^bus.p_data_in) : (~^bus.p_data_in);

`ifdef PISO_PARITY_EN
    assign load_frame = {1'b1, parity_bit, bus.p_data_in, 1'b0};
`else
    assign load_frame = {1'b1, bus.p_data_in, 1'b0};
`endif

    // Frame shifted right by one with an idle '1' filling from the top
    generate
        for (genvar gi = 0; gi < FRAME_LEN - 1; gi++) begin : g_shift
            assign shifted_frame[gi] = frame_reg[gi + 1];
        end
    endgenerate
    assign shifted_frame[FRAME_LEN-1] = 1'b1;

    // Frame next state: load wins over shift; nothing moves between ticks.
    // A load during a frame simply restarts it; the line keeps its current level
    // until the first shift puts the start bit out.
    always_comb begin
        frame_next   = frame_reg;
        bit_cnt_next = bit_cnt_reg;
        serial_next  = serial_reg;
        if (baud_tick_reg) begin
            if (bus.load) begin
                frame_next   = load_frame;
                bit_cnt_next = BIT_FULL;
            end else if (bus.shift) begin
                if (bit_cnt_reg != '0) begin
                    serial_next  = frame_reg[0];
                    frame_next   = shifted_frame;
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                end else begin
                    serial_next  = 1'b1;
                end
            end
        end
    end

    // Frame registers; reset aborts any frame and returns the line to idle high
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg   <= '1;
            bit_cnt_reg <= '0;
            serial_reg  <= 1'b1;
        end else begin
            frame_reg   <= frame_next;
            bit_cnt_reg <= bit_cnt_next;
            serial_reg  <= serial_next;
        end
    end

    assign bus.baud_tick  = baud_tick_reg;
    assign bus.parity_bit = parity_bit;
    assign bus.tx_empty   = (bit_cnt_reg == '0);
    assign bus.serial_out = serial_reg;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Scoreboard bench for uart_tx_piso: the stimulus process pushes the expected
// {serial_out, tx_empty} for every tick it drives; a monitor pops and compares one
// sys_clk after each baud tick. Frame length follows PISO_PARITY_EN like the design.
module tb_uart_tx_piso;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;   // 434
`ifdef PISO_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    typedef struct {
        logic  serial;
        logic  empty;
        int    id;
        string name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_tx_piso_if bus_if ();

    uart_tx_piso #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    int edge_cnt = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [FL-1:0] m_frame = '1;
    int            m_cnt   = 0;
    logic          m_line  = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [FL-1:0] build_frame(input logic [7:0] d, input logic eo);
`ifdef PISO_PARITY_EN
        logic p;
        p = eo ? (^d) : (~^d);
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    // Wait (bounded) for the next baud tick, sampled on the falling edge
    task automatic wait_tick(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < DIV + 4; i++) begin
            @(negedge clk);
            if (bus_if.baud_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: actual=no baud_tick required=tick within %0d cycles", name, DIV + 4);
        end
    endtask

    // Drive one tick's worth of control and queue the expected result
    task automatic tick_op(input logic ld, input logic sh, input logic [7:0] d,
                           input logic eo, input string name);
        bit   got;
        exp_t e;
        bus_if.load      = ld;
        bus_if.shift     = sh;
        bus_if.p_data_in = d;
        bus_if.even_odd  = eo;
        wait_tick(name, got);
        if (got) begin
            if (ld) begin
                m_frame = build_frame(d, eo);
                m_cnt   = FL;
            end else if (sh) begin
                if (m_cnt > 0) begin
                    m_line  = m_frame[0];
                    m_frame = {1'b1, m_frame[FL-1:1]};
                    m_cnt--;
                end else begin
                    m_line = 1'b1;
                end
            end
            e.serial = m_line;
            e.empty  = (m_cnt == 0);
            e.id     = txn_id;
            e.name   = name;
            txn_id++;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus_if.load  = 1'b0;
        bus_if.shift = 1'b0;
    endtask

    // Monitor: one falling edge after a tick was seen, the post-tick state is compared
    logic tick_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (tick_seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus_if.serial_out !== e.serial || bus_if.tx_empty !== e.empty) begin
                errors++;
                $display("FAIL txn %0d %s: actual serial=%b empty=%b required serial=%b empty=%b",
                         e.id, e.name, bus_if.serial_out, bus_if.tx_empty, e.serial, e.empty);
            end else begin
                $display("txn %0d %s: serial=%b empty=%b ok",
                         e.id, e.name, bus_if.serial_out, bus_if.tx_empty);
            end
        end
        tick_seen <= bus_if.baud_tick;
    end

    // Parity vectors: {data, even_odd, expected parity}
    logic [7:0] par_d   [6] = '{8'hCC, 8'hCC, 8'h01, 8'h01, 8'h55, 8'hFE};
    logic       par_eo  [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       par_exp [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};

    initial begin
        bit got;
        int e0;
        int last;

        bus_if.load      = 1'b0;
        bus_if.shift     = 1'b0;
        bus_if.even_odd  = 1'b1;
        bus_if.p_data_in = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("reset_serial_out", int'(bus_if.serial_out), 1);
        check_val("reset_tx_empty",   int'(bus_if.tx_empty),   1);
        check_val("reset_baud_tick",  int'(bus_if.baud_tick),  0);

        // Combinational parity
        for (int i = 0; i < 6; i++) begin
            bus_if.p_data_in = par_d[i];
            bus_if.even_odd  = par_eo[i];
            #1;
            check_val($sformatf("parity_%02h_eo%0d", par_d[i], par_eo[i]),
                      int'(bus_if.parity_bit), int'(par_exp[i]));
        end

        // Release reset and measure tick position and spacing
        @(negedge clk);
        rst_n = 1'b1;
        e0 = edge_cnt;
        last = 0;
        for (int k = 0; k <= 10; k++) begin
            wait_tick($sformatf("tick_%0d", k), got);
            if (!got) break;
            if (k == 0) check_val("first_tick_edges", edge_cnt - e0, DIV - 1);
            else        check_val($sformatf("tick_spacing_%0d", k), edge_cnt - last, DIV);
            last = edge_cnt;
        end

        // 0xCC even parity, then two idle shifts
        tick_op(1'b1, 1'b0, 8'hCC, 1'b1, "load_cc_even");
        for (int i = 0; i < FL + 2; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("cc_even_bit%0d", i));

        // 0xCC odd parity with a hold tick in the middle of the frame
        tick_op(1'b1, 1'b0, 8'hCC, 1'b0, "load_cc_odd");
        for (int i = 0; i < 2; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b0, $sformatf("cc_odd_bit%0d", i));
        tick_op(1'b0, 1'b0, 8'h00, 1'b0, "cc_odd_hold");
        for (int i = 2; i < FL + 1; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b0, $sformatf("cc_odd_bit%0d", i));

        // 0x01 even parity
        tick_op(1'b1, 1'b0, 8'h01, 1'b1, "load_01_even");
        for (int i = 0; i < FL; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("x01_bit%0d", i));

        // Abort: four bits of 0xCC, then reload 0x55 with shift also high (load wins)
        tick_op(1'b1, 1'b0, 8'hCC, 1'b1, "load_cc_abort");
        for (int i = 0; i < 4; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("abort_cc_bit%0d", i));
        tick_op(1'b1, 1'b1, 8'h55, 1'b1, "reload_55");
        for (int i = 0; i < FL + 1; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("x55_bit%0d", i));

        // Reset in the middle of a frame after five bits
        tick_op(1'b1, 1'b0, 8'hA5, 1'b1, "load_a5");
        for (int i = 0; i < 5; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("a5_bit%0d", i));
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midreset_serial_out", int'(bus_if.serial_out), 1);
        check_val("midreset_tx_empty",   int'(bus_if.tx_empty),   1);
        check_val("midreset_baud_tick",  int'(bus_if.baud_tick),  0);
        m_frame = '1;
        m_cnt   = 0;
        m_line  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            tick_op(1'b0, 1'b1, 8'h00, 1'b1, $sformatf("post_reset_shift%0d", i));

        // Every queued expectation must have been consumed by the monitor
        repeat (3) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
